rom_read_arbiter: RTL

Shares one synchronous-read instruction ROM between two requesters (port 0: instruction fetch, port 1: constant/table load). Accepts valid/ready read requests, grants at most one per cycle, drives the ROM address, tracks the ROM's one-cycle read latency and returns each word in a per-port registered response slot with backpressure. Sits between the core front end and the ROM instance.

---
 rtl/rom_arb_pkg.sv | 7 +
 rtl/rr_arbiter2.sv | 17 +
 rtl/rom_read_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types for the ROM read arbiter
// Exports NUM_PORTS, port_id_t (port index) and slot_state_e (per-port response slot state).
package rom_arb_pkg;
    localparam int NUM_PORTS = 2;
    typedef logic port_id_t;
    typedef enum logic [1:0] {EMPTY, INFLIGHT, FULL} slot_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way arbiter turning eligible ports into a one-hot grant
// Ports: eligible[1:0] in, last_grant in (round-robin build only), grant[1:0] out.
// Build option ROM_ARB_FIXED_PRIO_EN: port 0 always wins a tie and last_grant is not used.
module rr_arbiter2 import rom_arb_pkg::*; (
    input  logic [NUM_PORTS-1:0] eligible,
`ifndef ROM_ARB_FIXED_PRIO_EN
    input  port_id_t             last_grant,
`endif
    output logic [NUM_PORTS-1:0] grant
);
`ifdef ROM_ARB_FIXED_PRIO_EN
    assign grant = eligible[0] ? 2'b01 : {eligible[1], 1'b0};
`else
    // On a tie the port that did not win last time goes next.
    assign grant = (&eligible) ? (last_grant ? 2'b01 : 2'b10) : eligible;
`endif
endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one synchronous-read ROM between two requesters
// Ports: clk, rst_n (async, active low); req_valid/req_addr/req_ready request side per port;
// rsp_valid/rsp_data/rsp_ready registered response slot per port; rom_address/rom_data to the ROM.
// Build option ROM_ARB_FIXED_PRIO_EN: fixed priority (port 0 wins), no last_grant register.
module rom_read_arbiter import rom_arb_pkg::*; #(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_LENGTH  = 32,
    parameter int ADDR_W      = $clog2(MEM_LENGTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  req_valid,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      req_addr,
    output logic [NUM_PORTS-1:0]                  req_ready,
    output logic [NUM_PORTS-1:0]                  rsp_valid,
    output logic [NUM_PORTS-1:0][DATA_LENGTH-1:0] rsp_data,
    input  logic [NUM_PORTS-1:0]                  rsp_ready,
    output logic [ADDR_W-1:0]                     rom_address,
    input  logic [DATA_LENGTH-1:0]                rom_data
);
    slot_state_e                          slot_q [NUM_PORTS];
    slot_state_e                          slot_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][DATA_LENGTH-1:0] data_q, data_d;
    logic [ADDR_W-1:0]                    addr_q, addr_d;
    logic                                 tag_valid_q, tag_valid_d;
    port_id_t                             tag_port_q, tag_port_d;
    logic [NUM_PORTS-1:0]                 eligible, arb_grant, grant;
    port_id_t                             gnt_port;
`ifndef ROM_ARB_FIXED_PRIO_EN
    port_id_t                             last_q, last_d;
`endif

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            eligible[i] = req_valid[i] && (slot_q[i] == EMPTY || (slot_q[i] == FULL && rsp_ready[i]));
    end

    rr_arbiter2 u_arb (
        .eligible   (eligible),
`ifndef ROM_ARB_FIXED_PRIO_EN
        .last_grant (last_q),
`endif
        .grant      (arb_grant)
    );

    // Held low while in reset so no request is accepted before release.
    assign grant       = arb_grant & {NUM_PORTS{rst_n}};
    assign gnt_port    = grant[1];
    assign req_ready   = grant;
    assign rom_address = addr_d;
    assign rsp_data    = data_q;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            rsp_valid[i] = slot_q[i] == FULL;
    end

    always_comb begin
        addr_d      = |grant ? req_addr[gnt_port] : addr_q;
        tag_valid_d = |grant;
        tag_port_d  = gnt_port;
`ifndef ROM_ARB_FIXED_PRIO_EN
        last_d      = |grant ? gnt_port : last_q;
`endif
        data_d      = data_q;
        if (tag_valid_q) data_d[tag_port_q] = rom_data;
        for (int i = 0; i < NUM_PORTS; i++)
            slot_d[i] = grant[i] ? INFLIGHT :
                        slot_q[i] == INFLIGHT ? FULL :
                        (slot_q[i] == FULL && rsp_ready[i]) ? EMPTY : slot_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            tag_valid_q <= 1'b0;
            tag_port_q  <= 1'b0;
            data_q      <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
            for (int i = 0; i < NUM_PORTS; i++) slot_q[i] <= EMPTY;
        end else begin
            addr_q      <= addr_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            data_q      <= data_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
            for (int i = 0; i < NUM_PORTS; i++) slot_q[i] <= slot_d[i];
        end
    end
endmodule
